timer_seq_master: RTL and testbench
===================================

Name: timer_seq_master

Overview:
- Avalon-MM initiator that programs and services the interval-timer peripheral's 16-bit register file (3-bit address).
- Accepts a command (period, tick target, mode), then writes period low/high and control with START.
- Services each timeout by clearing status, counts ticks, and writes STOP when the target is reached or an abort arrives.
- Sits between fabric control logic and the timer slave, replacing CPU polling loops.

Parameters:
- TICK_W, 16, width of tick target and tick counter
- RD_LAT, 1, slave read latency in cycles (registered readdata)

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_period  in  32  period value loaded into the timer (interval = period+1 clocks)
- cmd_ticks  in  TICK_W  number of timeouts to wait; 0 is treated as 1
- cmd_continuous  in  1  1: CONT mode; 0: one-shot, restarted per tick
- cmd_abort  in  1  level; stops the sequence at the next safe state
- tick_pulse  out  1  one-cycle pulse per serviced timeout
- ticks_done  out  TICK_W  timeouts serviced in the current/last command
- done  out  1  one-cycle pulse at sequence end
- aborted  out  1  sticky until next accepted command; set on abort completion
- av_address  out  3  slave register index
- av_chipselect  out  1  slave select
- av_write_n  out  1  active-low write
- av_writedata  out  16  write data
- av_readdata  in  16  slave read data
- av_irq  in  1  slave interrupt

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: cmd_ready=1, tick_pulse=0, done=0, aborted=0, ticks_done=0, av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0. FSM resets to IDLE.
- All av_* outputs are registered. A write is exactly one cycle of chipselect=1, write_n=0; there is no waitrequest.
- Reads have no strobe: hold address with chipselect=1 and write_n=1 for RD_LAT+1 cycles, then sample readdata on the last edge.
- Register map:
  - 0 status: write clears TO; read bit0=TO, bit1=RUN
  - 1 control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP
  - 2 period_l, 3 period_h, 4/5 snap_l/snap_h
- FSM states: IDLE, WR_PL, WR_PH, GAP, WR_CTRL, WAIT, CLR, WR_STOP, CLR_FIN, FIN.
  - IDLE: on cmd_valid&&cmd_ready, latch the command, clear ticks_done and aborted, go to WR_PL.
  - WR_PL: write period[15:0] to addr 2. WR_PH: write period[31:16] to addr 3.
  - GAP: one idle cycle so the slave's period-triggered force_reload stop settles before START.
  - WR_CTRL: write addr 1 = {STOP=0, START=1, CONT=cmd_continuous, ITO=1}.
  - WAIT: on av_irq=1, go to CLR.
  - CLR: write addr 0 (data 0), pulse tick_pulse, increment ticks_done.
    - If ticks_done+1 == target: go to WR_STOP.
    - Else if continuous: go to WAIT.
    - Else (one-shot): go to WR_CTRL to restart.
  - WR_STOP: write addr 1 = 0x8 (STOP, ITO=0).
  - CLR_FIN: write addr 0 to clear any late TO.
  - FIN: pulse done, go to IDLE.
- WAIT holds off for 2 cycles after CLR, because irq deasserts one cycle after the status write. A stale irq must not double-count.
- cmd_abort is sampled in GAP, WAIT and WR_CTRL; in those states it goes to WR_STOP and sets aborted. In all other states abort is deferred to the next sampling point. Abort in IDLE is ignored.
- Simultaneous irq and abort in WAIT: abort wins and the tick is not counted.
- ticks_done saturates at all-ones and does not wrap.
- Reset mid-sequence: all outputs return to reset values immediately. Slave state is the slave's own concern.
- Latency: command accept to START write = 4 cycles (WR_PL, WR_PH, GAP, WR_CTRL).

Optional Feature:
- Macro: TIMER_SEQ_POLL_EN.
- Defined: ITO is written as 0 and av_irq is ignored. WAIT becomes a repeated read of addr 0 (RD_LAT+1 cycles per read); readdata bit0=1 advances to CLR. Abort is checked between reads.
- Undefined: interrupt-driven WAIT as above; no read cycles are ever issued.

Decomposition:
- Package timer_seq_pkg:
  - register index constants (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5)
  - control bit positions
  - FSM state enum
- One sub-module, timer_seq_avbus: a one-deep registered bus driver taking {op, addr, data} and producing av_* plus rd_done/rd_data. The FSM issues ops into it.

Test Plan:
- cmd_period=0x0009, cmd_ticks=3, continuous=1 with real timer slave:
  - exactly 3 tick_pulse, spaced 10 cycles, done once, ticks_done=3
  - bus trace shows writes 2:0x0009, 3:0x0000, 1:0x0007, then 0, 0, 0, 1:0x0008, 0
- One-shot, period=0x0004, ticks=2: control write 0x0005 issued twice, 2 ticks, done.
- cmd_ticks=0: treated as 1 → single tick_pulse, then STOP, done.
- Abort asserted 3 cycles into WAIT, period=0x00FF: STOP write within 2 cycles, aborted=1, ticks_done=0, no tick_pulse. aborted clears on next accepted command.
- irq held high 1 extra cycle after CLR (slave model): ticks_done increments once only.
- TIMER_SEQ_POLL_EN defined, period=0x0007, ticks=2: no ITO bit in control (0x0006), periodic reads of addr 0, 2 ticks, av_irq toggles ignored.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// timer_seq_pkg: register map, control bits, FSM states and bus ops shared by timer_seq_master
package timer_seq_pkg;
    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;
    localparam logic [2:0] REG_SNAPL   = 3'd4;
    localparam logic [2:0] REG_SNAPH   = 3'd5;
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;
    localparam logic [15:0] CTRL_STOP_WORD = 16'(1 << CTRL_STOP);
    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_GAP, S_WR_CTRL, S_WAIT, S_CLR, S_WR_STOP, S_CLR_FIN, S_FIN
    } state_t;
    typedef enum logic [1:0] {OP_NONE, OP_WR, OP_RD} bus_op_t;
endpackage

// File: rtl/timer_seq_avbus.sv
// timer_seq_avbus: one-deep registered Avalon-MM driver; one-cycle writes, RD_LAT+1-cycle reads
module timer_seq_avbus
    import timer_seq_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  bus_op_t     op,
    input  logic [2:0]  addr,
    input  logic [15:0] data,
    output logic        rd_busy,
    output logic        rd_done,
    output logic [15:0] rd_data,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata
);
    localparam int CW = $clog2(RD_LAT + 2);

    logic              cs_q, cs_d, wn_q, wn_d, rd_done_q, rd_done_d;
    logic [2:0]        addr_q, addr_d;
    logic [15:0]       wd_q, wd_d, rdat_q, rdat_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    assign rd_busy       = cs_q && wn_q;
    assign rd_done       = rd_done_q;
    assign rd_data       = rdat_q;
    assign av_address    = addr_q;
    assign av_chipselect = cs_q;
    assign av_write_n    = wn_q;
    assign av_writedata  = wd_q;

    // Hold a read strobe until its last cycle and capture readdata there; otherwise launch the next op
    always_comb begin
        cs_d      = 1'b0;
        wn_d      = 1'b1;
        addr_d    = addr_q;
        wd_d      = wd_q;
        cnt_d     = cnt_q;
        rd_done_d = 1'b0;
        rdat_d    = rdat_q;
        if (rd_busy) begin
            cs_d      = cnt_q != '0;
            cnt_d     = cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
            rd_done_d = cnt_q == '0;
            rdat_d    = cnt_q == '0 ? av_readdata : rdat_q;
        end else if (op != OP_NONE) begin
            cs_d   = 1'b1;
            wn_d   = op != OP_WR;
            addr_d = addr;
            wd_d   = op == OP_WR ? data : wd_q;
            cnt_d  = CW'(RD_LAT);
        end
    end

    // Bus output and read-capture registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q      <= 1'b0;
            wn_q      <= 1'b1;
            addr_q    <= '0;
            wd_q      <= '0;
            cnt_q     <= '0;
            rd_done_q <= 1'b0;
            rdat_q    <= '0;
        end else begin
            cs_q      <= cs_d;
            wn_q      <= wn_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            cnt_q     <= cnt_d;
            rd_done_q <= rd_done_d;
            rdat_q    <= rdat_d;
        end
    end
endmodule

// File: rtl/timer_seq_master.sv
// timer_seq_master: programs the interval timer and services timeouts; TIMER_SEQ_POLL_EN polls status instead of av_irq
module timer_seq_master
    import timer_seq_pkg::*;
#(
    parameter int TICK_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_period,
    input  logic [TICK_W-1:0] cmd_ticks,
    input  logic              cmd_continuous,
    input  logic              cmd_abort,
    output logic              tick_pulse,
    output logic [TICK_W-1:0] ticks_done,
    output logic              done,
    output logic              aborted,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              av_irq
);
`ifdef TIMER_SEQ_POLL_EN
    localparam logic ITO_EN = 1'b0;
`else
    localparam logic ITO_EN = 1'b1;
`endif

    state_t            state_q, state_d;
    logic [31:0]       per_q, per_d;
    logic [TICK_W-1:0] tgt_q, tgt_d, ticks_q, ticks_d, ticks_inc;
    logic              cont_q, cont_d, aborted_q, aborted_d, tick_q, tick_d, done_q, done_d;
    logic [1:0]        hold_q, hold_d;
    bus_op_t           op;
    logic [2:0]        op_addr;
    logic [15:0]       op_data, ctrl_word, rd_data;
    logic              rd_busy, rd_done, tick_last, unused_ok;

    assign cmd_ready  = state_q == S_IDLE;
    assign tick_pulse = tick_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign ticks_done = ticks_q;
    assign ticks_inc  = &ticks_q ? ticks_q : ticks_q + 1'b1;
    assign tick_last  = ({1'b0, ticks_q} + 1'b1) == {1'b0, tgt_q};
    assign ctrl_word  = (16'd1 << CTRL_START) | (16'(cont_q) << CTRL_CONT) | (16'(ITO_EN) << CTRL_ITO);
`ifdef TIMER_SEQ_POLL_EN
    assign unused_ok  = ^{av_irq, rd_data[15:1]};
`else
    assign unused_ok  = ^{rd_busy, rd_done, rd_data};
`endif

    timer_seq_avbus #(.RD_LAT(RD_LAT)) u_bus (
        .clk(clk), .reset_n(reset_n), .op(op), .addr(op_addr), .data(op_data),
        .rd_busy(rd_busy), .rd_done(rd_done), .rd_data(rd_data),
        .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
        .av_writedata(av_writedata), .av_readdata(av_readdata)
    );

    // Sequencer next state and bus op; the post-clear hold-off keeps a lingering irq from counting twice
    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        tgt_d     = tgt_q;
        cont_d    = cont_q;
        ticks_d   = ticks_q;
        aborted_d = aborted_q;
        hold_d    = hold_q != '0 ? hold_q - 1'b1 : hold_q;
        tick_d    = state_q == S_CLR;
        done_d    = state_q == S_FIN;
        op        = OP_NONE;
        op_addr   = REG_STATUS;
        op_data   = '0;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                per_d     = cmd_period;
                tgt_d     = cmd_ticks == '0 ? TICK_W'(1) : cmd_ticks;
                cont_d    = cmd_continuous;
                ticks_d   = '0;
                aborted_d = 1'b0;
                state_d   = S_WR_PL;
            end
            S_WR_PL: begin
                op      = OP_WR;
                op_addr = REG_PERIODL;
                op_data = per_q[15:0];
                state_d = S_WR_PH;
            end
            S_WR_PH: begin
                op      = OP_WR;
                op_addr = REG_PERIODH;
                op_data = per_q[31:16];
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d   = cmd_abort ? S_WR_STOP : S_WR_CTRL;
                aborted_d = aborted_q | cmd_abort;
            end
            S_WR_CTRL: if (cmd_abort) begin
                state_d   = S_WR_STOP;
                aborted_d = 1'b1;
            end else begin
                op      = OP_WR;
                op_addr = REG_CONTROL;
                op_data = ctrl_word;
                state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef TIMER_SEQ_POLL_EN
                if (rd_done && rd_data[0]) state_d = S_CLR;
                else if (!rd_busy && cmd_abort) begin
                    state_d   = S_WR_STOP;
                    aborted_d = 1'b1;
                end else if (!rd_busy && hold_q == '0) op = OP_RD;
`else
                if (cmd_abort) begin
                    state_d   = S_WR_STOP;
                    aborted_d = 1'b1;
                end else if (av_irq && hold_q == '0) state_d = S_CLR;
`endif
            end
            S_CLR: begin
                op      = OP_WR;
                ticks_d = ticks_inc;
                hold_d  = 2'd2;
                state_d = tick_last ? S_WR_STOP : (cont_q ? S_WAIT : S_WR_CTRL);
            end
            S_WR_STOP: begin
                op      = OP_WR;
                op_addr = REG_CONTROL;
                op_data = CTRL_STOP_WORD;
                state_d = S_CLR_FIN;
            end
            S_CLR_FIN: begin
                op      = OP_WR;
                state_d = S_FIN;
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            per_q     <= '0;
            tgt_q     <= '0;
            cont_q    <= 1'b0;
            ticks_q   <= '0;
            aborted_q <= 1'b0;
            hold_q    <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            tgt_q     <= tgt_d;
            cont_q    <= cont_d;
            ticks_q   <= ticks_d;
            aborted_q <= aborted_d;
            hold_q    <= hold_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_timer_seq_master.sv
// tb_timer_seq_master: timer slave model plus bus-write scoreboard for timer_seq_master
module tb_timer_seq_master;
`ifdef TIMER_SEQ_POLL_EN
    localparam bit POLL = 1'b1;
    localparam int ABORT_LAT = 4;
`else
    localparam bit POLL = 1'b0;
    localparam int ABORT_LAT = 2;
`endif
    localparam logic [15:0] ITO = POLL ? 16'd0 : 16'd1;

    logic        clk = 1'b0, reset_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_continuous = 1'b0, cmd_abort = 1'b0;
    logic [31:0] cmd_period = '0;
    logic [15:0] cmd_ticks = '0;
    logic        cmd_ready, tick_pulse, done, aborted, av_chipselect, av_write_n, av_irq;
    logic [15:0] ticks_done, av_writedata, av_readdata;
    logic [2:0]  av_address;

    always #5 clk = ~clk;

    timer_seq_master #(.TICK_W(16), .RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_period(cmd_period), .cmd_ticks(cmd_ticks), .cmd_continuous(cmd_continuous),
        .cmd_abort(cmd_abort), .tick_pulse(tick_pulse), .ticks_done(ticks_done), .done(done),
        .aborted(aborted), .av_address(av_address), .av_chipselect(av_chipselect),
        .av_write_n(av_write_n), .av_writedata(av_writedata), .av_readdata(av_readdata),
        .av_irq(av_irq)
    );

    // Interval timer slave model: interval = period+1 clocks, registered readdata
    logic [15:0] s_pl, s_ph, s_rd;
    logic [31:0] s_cnt;
    logic        s_run, s_to, s_ito, s_cont, s_irq_d;
    logic        stale = 1'b0, irq_tog = 1'b0;
    always @(posedge clk) irq_tog <= ~irq_tog;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_pl <= '0; s_ph <= '0; s_rd <= '0; s_cnt <= '0;
            s_run <= 1'b0; s_to <= 1'b0; s_ito <= 1'b0; s_cont <= 1'b0; s_irq_d <= 1'b0;
        end else begin
            s_irq_d <= s_to & s_ito;
            if (s_run) begin
                if (s_cnt == 0) begin
                    s_to  <= 1'b1;
                    s_cnt <= {s_ph, s_pl};
                    if (!s_cont) s_run <= 1'b0;
                end else s_cnt <= s_cnt - 1;
            end
            if (av_chipselect && !av_write_n) begin
                case (av_address)
                    3'd0: s_to <= 1'b0;
                    3'd1: begin
                        s_ito  <= av_writedata[0];
                        s_cont <= av_writedata[1];
                        if (av_writedata[2]) begin s_run <= 1'b1; s_cnt <= {s_ph, s_pl}; end
                        if (av_writedata[3]) s_run <= 1'b0;
                    end
                    3'd2: begin s_pl <= av_writedata; s_run <= 1'b0; end
                    3'd3: begin s_ph <= av_writedata; s_run <= 1'b0; end
                    default: ;
                endcase
            end
            s_rd <= {14'd0, s_run, s_to};
        end
    end
    assign av_readdata = s_rd;
    assign av_irq = POLL ? irq_tog : ((s_to & s_ito) | (stale & s_irq_d));

    int checks = 0, failures = 0;
    int n_tick = 0, n_done = 0, n_rd = 0, n_rd_bad = 0, cyc = 0;
    int tick_t[$];
    logic [18:0] exp_q[$];
    logic [18:0] sb_e;

    // Monitor: scoreboard every bus write against the expected queue, log ticks, done pulses and reads
    always @(negedge clk) begin
        cyc++;
        if (av_chipselect && !av_write_n) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL bus_write unexpected got=%0d:%h exp=none", av_address, av_writedata);
            end else begin
                sb_e = exp_q.pop_front();
                if ({av_address, av_writedata} !== sb_e) begin
                    failures++;
                    $display("FAIL bus_write got=%0d:%h exp=%0d:%h", av_address, av_writedata, sb_e[18:16], sb_e[15:0]);
                end
            end
        end
        if (av_chipselect && av_write_n) begin
            n_rd++;
            if (av_address != 3'd0) n_rd_bad++;
        end
        if (tick_pulse) begin n_tick++; tick_t.push_back(cyc); end
        if (done) n_done++;
    end

    task automatic push_seq(input logic [31:0] p, input int t, input bit cont);
        int n = (t == 0) ? 1 : t;
        logic [15:0] ctrl = 16'h0004 | (cont ? 16'h0002 : 16'h0000) | ITO;
        exp_q.push_back({3'd2, p[15:0]});
        exp_q.push_back({3'd3, p[31:16]});
        exp_q.push_back({3'd1, ctrl});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({3'd0, 16'h0000});
            if (!cont && i < n - 1) exp_q.push_back({3'd1, ctrl});
        end
        exp_q.push_back({3'd1, 16'h0008});
        exp_q.push_back({3'd0, 16'h0000});
    endtask

    task automatic issue(input logic [31:0] p, input logic [15:0] t, input bit c);
        @(negedge clk);
        cmd_period = p; cmd_ticks = t; cmd_continuous = c; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL %s_done got=timeout exp=done_pulse", name); end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, tick_pulse, done, aborted, av_chipselect, av_write_n} !== 6'b100001) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=100001", {cmd_ready, tick_pulse, done, aborted, av_chipselect, av_write_n});
        end
        checks++;
        if ({av_address, av_writedata, ticks_done} !== 35'd0) begin
            failures++;
            $display("FAIL reset_data got=%0d:%h:%0d exp=0:0000:0", av_address, av_writedata, ticks_done);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_continuous();
        int bt = tick_t.size(), bn = n_tick, bd = n_done, br = n_rd;
        push_seq(32'h9, 3, 1'b1);
        issue(32'h9, 16'd3, 1'b1);
        wait_done("cont");
        checks++;
        if (n_tick - bn != 3) begin failures++; $display("FAIL cont_ticks got=%0d exp=3", n_tick - bn); end
        checks++;
        if (n_done - bd != 1) begin failures++; $display("FAIL cont_done_count got=%0d exp=1", n_done - bd); end
        checks++;
        if (ticks_done !== 16'd3) begin failures++; $display("FAIL cont_ticks_done got=%0d exp=3", ticks_done); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL cont_missing_writes got=%0d exp=0", exp_q.size()); exp_q.delete(); end
`ifndef TIMER_SEQ_POLL_EN
        checks++;
        if (tick_t.size() < bt + 3 || tick_t[bt+1] - tick_t[bt] != 10 || tick_t[bt+2] - tick_t[bt+1] != 10) begin
            failures++;
            $display("FAIL cont_spacing got=%0d ticks exp=10_cycle_gaps", tick_t.size() - bt);
        end
        checks++;
        if (n_rd != br) begin failures++; $display("FAIL cont_no_reads got=%0d exp=0", n_rd - br); end
`endif
    endtask

    task automatic test_oneshot();
        int bn = n_tick;
        push_seq(32'h4, 2, 1'b0);
        issue(32'h4, 16'd2, 1'b0);
        wait_done("oneshot");
        checks++;
        if (n_tick - bn != 2) begin failures++; $display("FAIL oneshot_ticks got=%0d exp=2", n_tick - bn); end
        checks++;
        if (ticks_done !== 16'd2) begin failures++; $display("FAIL oneshot_ticks_done got=%0d exp=2", ticks_done); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL oneshot_missing_writes got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_abort();
        int bn = n_tick, k = 0;
        bit seen = 1'b0;
        logic [15:0] ctrl = 16'h0006 | ITO;
        exp_q.push_back({3'd2, 16'h00FF});
        exp_q.push_back({3'd3, 16'h0000});
        exp_q.push_back({3'd1, ctrl});
        exp_q.push_back({3'd1, 16'h0008});
        exp_q.push_back({3'd0, 16'h0000});
        issue(32'hFF, 16'd5, 1'b1);
        for (int i = 0; i < 20 && !seen; i++) begin
            seen = av_chipselect && !av_write_n && av_address == 3'd1;
            if (!seen) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        cmd_abort = 1'b1;
        seen = 1'b0;
        while (k < 8 && !seen) begin
            @(negedge clk);
            k++;
            seen = av_chipselect && !av_write_n && av_address == 3'd1 && av_writedata == 16'h0008;
        end
        checks++;
        if (!seen || k > ABORT_LAT) begin failures++; $display("FAIL abort_stop_latency got=%0d exp<=%0d", k, ABORT_LAT); end
        wait_done("abort");
        cmd_abort = 1'b0;
        checks++;
        if (aborted !== 1'b1) begin failures++; $display("FAIL abort_flag got=%b exp=1", aborted); end
        checks++;
        if (ticks_done !== 16'd0 || n_tick != bn) begin
            failures++;
            $display("FAIL abort_no_tick got=%0d/%0d exp=0/0", ticks_done, n_tick - bn);
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL abort_missing_writes got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_zero_ticks();
        int bn = n_tick;
        push_seq(32'h5, 0, 1'b1);
        issue(32'h5, 16'd0, 1'b1);
        checks++;
        if (aborted !== 1'b0) begin failures++; $display("FAIL zero_aborted_clear got=%b exp=0", aborted); end
        wait_done("zero");
        checks++;
        if (n_tick - bn != 1 || ticks_done !== 16'd1) begin
            failures++;
            $display("FAIL zero_ticks got=%0d/%0d exp=1/1", n_tick - bn, ticks_done);
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL zero_missing_writes got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_stale_irq();
        int bn = n_tick;
        stale = 1'b1;
        push_seq(32'h9, 3, 1'b1);
        issue(32'h9, 16'd3, 1'b1);
        wait_done("stale");
        stale = 1'b0;
        checks++;
        if (n_tick - bn != 3 || ticks_done !== 16'd3) begin
            failures++;
            $display("FAIL stale_irq_ticks got=%0d/%0d exp=3/3", n_tick - bn, ticks_done);
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL stale_missing_writes got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid();
        push_seq(32'h20, 2, 1'b1);
        issue(32'h20, 16'd2, 1'b1);
        repeat (8) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, tick_pulse, done, aborted, av_chipselect, av_write_n} !== 6'b100001) begin
            failures++;
            $display("FAIL midreset_ctrl got=%b exp=100001", {cmd_ready, tick_pulse, done, aborted, av_chipselect, av_write_n});
        end
        checks++;
        if ({av_address, av_writedata, ticks_done} !== 35'd0) begin
            failures++;
            $display("FAIL midreset_data got=%0d:%h:%0d exp=0:0000:0", av_address, av_writedata, ticks_done);
        end
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

`ifdef TIMER_SEQ_POLL_EN
    task automatic test_poll();
        int br = n_rd, bb = n_rd_bad, bn = n_tick;
        push_seq(32'h7, 2, 1'b1);
        issue(32'h7, 16'd2, 1'b1);
        wait_done("poll");
        checks++;
        if (n_rd - br < 4 || n_rd_bad != bb) begin
            failures++;
            $display("FAIL poll_reads got=%0d/%0d exp=>=4/0", n_rd - br, n_rd_bad - bb);
        end
        checks++;
        if (n_tick - bn != 2 || ticks_done !== 16'd2) begin
            failures++;
            $display("FAIL poll_ticks got=%0d/%0d exp=2/2", n_tick - bn, ticks_done);
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL poll_missing_writes got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_continuous();
        test_oneshot();
        test_abort();
        test_zero_ticks();
        test_stale_irq();
        test_reset_mid();
`ifdef TIMER_SEQ_POLL_EN
        test_poll();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
